dice_result_display: RTL and testbench

- Receiving end of the dice roll interface: consumes the roll button and the 3-bit dice value from the dice counter.
- Debounces the button and tracks roll start and stop.
- After the roll ends and the value has settled, captures the value and drives a 7-LED pip pattern, with a spin animation while rolling.
- Sits between the dice counter output and the board LEDs; runs on the fast system clock.

---
 rtl/dice_result_display_if.sv | 25 ++
 rtl/dice_result_display.sv | 222 ++++++++++++++++++++++
 tb/tb_dice_result_display.sv | 174 +++++++++++++++++
 3 files changed

// File: rtl/dice_result_display_if.sv
// Dice roll interface: roll button and dice value in, pip LEDs and result status out.
// Optional DICE_HISTORY_EN adds the 12-bit history of the last four accepted results.
interface dice_result_display_if;
  logic       roll_button;
  logic [2:0] dice_in;
  logic [6:0] pips;
  logic [2:0] result;
  logic       result_valid;
  logic       rolling;
  logic       err;
  logic [7:0] roll_count;
`ifdef DICE_HISTORY_EN
  logic [11:0] history;

  modport master (output roll_button, dice_in,
                  input  pips, result, result_valid, rolling, err, roll_count, history);
  modport slave  (input  roll_button, dice_in,
                  output pips, result, result_valid, rolling, err, roll_count, history);
`else
  modport master (output roll_button, dice_in,
                  input  pips, result, result_valid, rolling, err, roll_count);
  modport slave  (input  roll_button, dice_in,
                  output pips, result, result_valid, rolling, err, roll_count);
`endif
endinterface

// File: rtl/dice_result_display.sv
// Dice result display: debounces the roll button, animates while rolling, captures the settled
// dice value and drives the 7-LED pip pattern. Optional result history under DICE_HISTORY_EN.
module dice_result_display #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int SETTLE_CYCLES   = 8,
  parameter int ANIM_DIV        = 16
) (
  input logic                   clk,
  input logic                   reset,
  dice_result_display_if.slave  dice_if
);

  localparam int DEB_W  = $clog2(DEBOUNCE_CYCLES);
  localparam int SET_W  = $clog2(SETTLE_CYCLES + 1);
  localparam int ANIM_W = $clog2(ANIM_DIV);
  localparam logic [DEB_W-1:0]  DEB_LAST  = DEB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [SET_W-1:0]  SET_LAST  = SET_W'(SETTLE_CYCLES - 1);
  localparam logic [ANIM_W-1:0] ANIM_LAST = ANIM_W'(ANIM_DIV - 1);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ROLLING = 2'd1,
    ST_SETTLE  = 2'd2,
    ST_SHOW    = 2'd3
  } state_t;

  function automatic logic [6:0] face_pips(input logic [2:0] v);
    case (v)
      3'd1:    face_pips = 7'h08;
      3'd2:    face_pips = 7'h41;
      3'd3:    face_pips = 7'h49;
      3'd4:    face_pips = 7'h63;
      3'd5:    face_pips = 7'h6B;
      3'd6:    face_pips = 7'h77;
      default: face_pips = 7'h00;
    endcase
  endfunction

  // Clockwise spin around the outer pips: TL, TR, MR, BR, BL, ML.
  function automatic logic [6:0] spin_pips(input logic [2:0] idx);
    case (idx)
      3'd0:    spin_pips = 7'h01;
      3'd1:    spin_pips = 7'h02;
      3'd2:    spin_pips = 7'h10;
      3'd3:    spin_pips = 7'h40;
      3'd4:    spin_pips = 7'h20;
      3'd5:    spin_pips = 7'h04;
      default: spin_pips = 7'h00;
    endcase
  endfunction

  function automatic logic value_ok(input logic [2:0] v);
    value_ok = (v != 3'd0) && (v != 3'd7);
  endfunction

  logic [1:0]        btn_sync_r;
  logic [2:0]        dice_meta_r, dice_sync_r;
  logic              deb_level_r;
  logic [DEB_W-1:0]  deb_cnt_r;
  logic              deb_toggle_s, deb_rise_s, deb_fall_s;
  state_t            state_r, next_state_s;
  logic              capture_s;
  logic [SET_W-1:0]  settle_cnt_r;
  logic [ANIM_W-1:0] anim_cnt_r;
  logic [2:0]        anim_idx_r;
  logic [6:0]        pips_r;
  logic [2:0]        result_r;
  logic              result_valid_r, rolling_r, err_r;
  logic [7:0]        roll_count_r;

  // Two-flop synchronisers for the button and each dice bit.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      btn_sync_r  <= 2'b00;
      dice_meta_r <= 3'd0;
      dice_sync_r <= 3'd0;
    end else begin
      btn_sync_r  <= {btn_sync_r[0], dice_if.roll_button};
      dice_meta_r <= dice_if.dice_in;
      dice_sync_r <= dice_meta_r;
    end
  end

  // Debounce edge detect: level flips on the last of DEBOUNCE_CYCLES differing samples.
  always_comb begin
    deb_toggle_s = 1'b0;
    if ((btn_sync_r[1] != deb_level_r) && (deb_cnt_r == DEB_LAST)) begin
      deb_toggle_s = 1'b1;
    end else begin
      deb_toggle_s = 1'b0;
    end
    deb_rise_s = deb_toggle_s & ~deb_level_r;
    deb_fall_s = deb_toggle_s &  deb_level_r;
  end

  // Debounce level and run-length counter.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      deb_level_r <= 1'b0;
      deb_cnt_r   <= '0;
    end else if (deb_toggle_s) begin
      deb_level_r <= ~deb_level_r;
      deb_cnt_r   <= '0;
    end else if (btn_sync_r[1] != deb_level_r) begin
      deb_cnt_r   <= deb_cnt_r + DEB_W'(1);
    end else begin
      deb_cnt_r   <= '0;
    end
  end

  // Next-state logic; a re-press during SETTLE wins over settle expiry.
  always_comb begin
    next_state_s = state_r;
    capture_s    = 1'b0;
    case (state_r)
      ST_IDLE, ST_SHOW: begin
        if (deb_rise_s) next_state_s = ST_ROLLING;
        else            next_state_s = state_r;
      end
      ST_ROLLING: begin
        if (deb_fall_s) next_state_s = ST_SETTLE;
        else            next_state_s = ST_ROLLING;
      end
      ST_SETTLE: begin
        if (deb_rise_s) begin
          next_state_s = ST_ROLLING;
        end else if (settle_cnt_r == SET_LAST) begin
          capture_s = 1'b1;
          if (value_ok(dice_sync_r) || (result_r != 3'd0)) next_state_s = ST_SHOW;
          else                                             next_state_s = ST_IDLE;
        end else begin
          next_state_s = ST_SETTLE;
        end
      end
      default: next_state_s = ST_IDLE;
    endcase
  end

  // State register plus animation and settle timers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r      <= ST_IDLE;
      anim_cnt_r   <= '0;
      anim_idx_r   <= 3'd0;
      settle_cnt_r <= '0;
    end else begin
      state_r <= next_state_s;
      if ((next_state_s == ST_ROLLING) && (state_r != ST_ROLLING)) begin
        anim_cnt_r <= '0;
        anim_idx_r <= 3'd0;
      end else if (state_r == ST_ROLLING) begin
        if (anim_cnt_r == ANIM_LAST) begin
          anim_cnt_r <= '0;
          anim_idx_r <= (anim_idx_r == 3'd5) ? 3'd0 : anim_idx_r + 3'd1;
        end else begin
          anim_cnt_r <= anim_cnt_r + ANIM_W'(1);
        end
      end else begin
        anim_cnt_r <= anim_cnt_r;
      end
      if (state_r != ST_SETTLE)           settle_cnt_r <= '0;
      else if (settle_cnt_r != SET_LAST)  settle_cnt_r <= settle_cnt_r + SET_W'(1);
      else                                settle_cnt_r <= settle_cnt_r;
    end
  end

  // Registered result, status and pip outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pips_r         <= 7'h00;
      result_r       <= 3'd0;
      result_valid_r <= 1'b0;
      rolling_r      <= 1'b0;
      err_r          <= 1'b0;
      roll_count_r   <= 8'd0;
    end else begin
      result_valid_r <= 1'b0;
      rolling_r      <= (next_state_s == ST_ROLLING);
      if (capture_s) begin
        if (value_ok(dice_sync_r)) begin
          result_r       <= dice_sync_r;
          result_valid_r <= 1'b1;
          err_r          <= 1'b0;
          roll_count_r   <= (roll_count_r == 8'hFF) ? roll_count_r : roll_count_r + 8'd1;
        end else begin
          err_r <= 1'b1;
        end
      end
      case (state_r)
        ST_IDLE:               pips_r <= 7'h00;
        ST_ROLLING, ST_SETTLE: pips_r <= spin_pips(anim_idx_r);
        ST_SHOW:               pips_r <= face_pips(result_r);
        default:               pips_r <= 7'h00;
      endcase
    end
  end

`ifdef DICE_HISTORY_EN
  logic [11:0] history_r;

  // History shifts only on accepted captures, newest in the low bits.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      history_r <= 12'h000;
    end else if (capture_s && value_ok(dice_sync_r)) begin
      history_r <= {history_r[8:0], dice_sync_r};
    end else begin
      history_r <= history_r;
    end
  end

  assign dice_if.history = history_r;
`endif

  assign dice_if.pips         = pips_r;
  assign dice_if.result       = result_r;
  assign dice_if.result_valid = result_valid_r;
  assign dice_if.rolling      = rolling_r;
  assign dice_if.err          = err_r;
  assign dice_if.roll_count   = roll_count_r;

endmodule

// File: tb/tb_dice_result_display.sv
// Directed bench for dice_result_display with default parameters (debounce 4, settle 8, anim 16).
module tb_dice_result_display;

  logic clk;
  logic reset;
  int   checks;
  int   errors;
  int   p;

  dice_result_display_if dif ();

  dice_result_display dut (
    .clk     (clk),
    .reset   (reset),
    .dice_if (dif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [11:0] got, input logic [11:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, got, exp);
    end
  endtask

  // Full press/release cycle; counts result_valid pulses in the settle window.
  task automatic roll(input logic [2:0] v, output int pulses);
    dif.dice_in = v;
    tick(3);
    dif.roll_button = 1'b1;
    tick(10);
    dif.roll_button = 1'b0;
    pulses = 0;
    repeat (18) begin
      tick(1);
      if (dif.result_valid === 1'b1) pulses++;
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    reset = 1'b0;
    dif.roll_button = 1'b0;
    dif.dice_in = 3'd5;
    tick(3);
    check("rst_pips", dif.pips, 12'h00);
    check("rst_result", dif.result, 12'h0);
    check("rst_valid", dif.result_valid, 12'h0);
    check("rst_rolling", dif.rolling, 12'h0);
    check("rst_err", dif.err, 12'h0);
    check("rst_count", dif.roll_count, 12'h0);

    // Reset asserted mid-roll clears outputs at once.
    reset = 1'b1;
    tick(2);
    dif.roll_button = 1'b1;
    tick(30);
    check("midroll_rolling", dif.rolling, 12'h1);
    reset = 1'b0;
    #1;
    check("async_rst_rolling", dif.rolling, 12'h0);
    check("async_rst_pips", dif.pips, 12'h00);
    dif.roll_button = 1'b0;
    tick(2);
    reset = 1'b1;
    tick(10);
    check("post_rst_rolling", dif.rolling, 12'h0);
    check("post_rst_pips", dif.pips, 12'h00);

    // Three-cycle glitch is shorter than the debounce window.
    dif.roll_button = 1'b1;
    tick(3);
    dif.roll_button = 1'b0;
    tick(10);
    check("glitch_rolling", dif.rolling, 12'h0);
    check("glitch_pips", dif.pips, 12'h00);

    // First roll: animation stepping and capture of 5.
    dif.roll_button = 1'b1;
    tick(5);
    check("deb_not_yet", dif.rolling, 12'h0);
    tick(1);
    check("deb_rolling", dif.rolling, 12'h1);
    tick(1);
    check("anim_tl", dif.pips, 12'h01);
    tick(16);
    check("anim_tr", dif.pips, 12'h02);
    tick(16);
    check("anim_mr", dif.pips, 12'h10);
    tick(16);
    check("anim_br", dif.pips, 12'h40);
    dif.roll_button = 1'b0;
    tick(13);
    check("valid_early", dif.result_valid, 12'h0);
    tick(1);
    check("valid_pulse", dif.result_valid, 12'h1);
    check("result5", dif.result, 12'h5);
    check("count1", dif.roll_count, 12'h1);
    tick(1);
    check("valid_single", dif.result_valid, 12'h0);
    check("pips5", dif.pips, 12'h6B);

    // Out-of-range capture keeps the previous result and sets err.
    roll(3'd7, p);
    check("err7_pulses", p, 12'h0);
    check("err7_err", dif.err, 12'h1);
    check("err7_result", dif.result, 12'h5);
    check("err7_pips", dif.pips, 12'h6B);
    check("err7_count", dif.roll_count, 12'h1);
    roll(3'd2, p);
    check("r2_pulses", p, 12'h1);
    check("r2_err", dif.err, 12'h0);
    check("r2_result", dif.result, 12'h2);
    check("r2_pips", dif.pips, 12'h41);
    check("r2_count", dif.roll_count, 12'h2);

    // Re-press during SETTLE restarts the animation without capturing.
    dif.dice_in = 3'd3;
    tick(3);
    dif.roll_button = 1'b1;
    tick(10);
    dif.roll_button = 1'b0;
    tick(6);
    check("settle_rolling", dif.rolling, 12'h0);
    check("settle_hold", dif.pips, 12'h01);
    dif.roll_button = 1'b1;
    p = 0;
    repeat (8) begin
      tick(1);
      if (dif.result_valid === 1'b1) p++;
    end
    check("repress_pulses", p, 12'h0);
    check("repress_rolling", dif.rolling, 12'h1);
    check("repress_pips", dif.pips, 12'h01);
    check("repress_result", dif.result, 12'h2);
    dif.roll_button = 1'b0;
    tick(18);
    check("r3_result", dif.result, 12'h3);
    check("r3_pips", dif.pips, 12'h49);
    check("r3_count", dif.roll_count, 12'h3);

    // Saturation of the roll counter.
    for (int i = 0; i < 252; i++) roll(3'((i % 6) + 1), p);
    check("count255", dif.roll_count, 12'hFF);
    for (int i = 0; i < 4; i++) roll(3'd4, p);
    check("sat_pulse", p, 12'h1);
    check("sat_count", dif.roll_count, 12'hFF);
    check("sat_result", dif.result, 12'h4);
    check("sat_pips", dif.pips, 12'h63);

`ifdef DICE_HISTORY_EN
    roll(3'd1, p);
    roll(3'd2, p);
    roll(3'd3, p);
    roll(3'd4, p);
    roll(3'd7, p);
    roll(3'd6, p);
    check("history", dif.history, {3'd2, 3'd3, 3'd4, 3'd6});
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
